// File: rtl/vector_bitwise_seq.sv
// vector_bitwise_seq
//   Runs one vector bitwise/min/max instruction (vd = vs2 op vs1/scalar) over
//   an LMUL register group, one register per two cycles (READ then EXEC),
//   using an external combinational vector_bitwise_unit.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   start / ready         launch handshake; start is only accepted in IDLE
//   op, sew, lmul, vl,    instruction configuration, sampled at accept
//   vm, use_scalar,
//   scalar, vs*_addr,
//   v0_data
//   rd_addr1/2            register-file read addresses (vs1, vs2)
//   rd_data1/2            register-file read data, valid the cycle after
//   alu_a/b/op/sew        operands and controls to the bitwise unit
//   alu_result            result from the bitwise unit
//   wr_en/addr/data/be    register-file write port with byte enables
//   done, error           one-cycle completion pulse, error flag with it
module vector_bitwise_seq #(
  parameter int unsigned VLEN = 512,
  parameter int unsigned VL_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ready,
  input  logic [4:0]        op,
  input  logic [1:0]        sew,
  input  logic [1:0]        lmul,
  input  logic [VL_W-1:0]   vl,
  input  logic              vm,
  input  logic              use_scalar,
  input  logic [63:0]       scalar,
  input  logic [4:0]        vs1_addr,
  input  logic [4:0]        vs2_addr,
  input  logic [4:0]        vd_addr,
  input  logic [VLEN-1:0]   v0_data,
  output logic [4:0]        rd_addr1,
  output logic [4:0]        rd_addr2,
  input  logic [VLEN-1:0]   rd_data1,
  input  logic [VLEN-1:0]   rd_data2,
  output logic [VLEN-1:0]   alu_a,
  output logic [VLEN-1:0]   alu_b,
  output logic [4:0]        alu_op,
  output logic [1:0]        alu_sew,
  input  logic [VLEN-1:0]   alu_result,
  output logic              wr_en,
  output logic [4:0]        wr_addr,
  output logic [VLEN-1:0]   wr_data,
  output logic [VLEN/8-1:0] wr_be,
  output logic              done,
  output logic              error
);

  localparam int unsigned VLENB = VLEN / 8;
  localparam logic [VLENB-1:0] ONE_B = {{(VLENB-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    FIN
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [4:0]        op_q, op_d;
  logic [1:0]        sew_q, sew_d;
  logic [1:0]        lmul_q, lmul_d;
  logic [VL_W-1:0]   vl_q, vl_d;
  logic              vm_q, vm_d;
  logic              use_scalar_q, use_scalar_d;
  logic [63:0]       scalar_q, scalar_d;
  logic [4:0]        vs1_q, vs1_d;
  logic [4:0]        vs2_q, vs2_d;
  logic [4:0]        vd_q, vd_d;
  logic [VLEN-1:0]   v0_q, v0_d;
  logic              err_q, err_d;

  logic [4:0]        amask;
  logic              illegal;
  logic [2:0]        idx_last;
  logic [VLEN-1:0]   scalar_rep;
  logic [VLENB-1:0]  be;

  // Group alignment check on the incoming configuration.
  always_comb begin
    amask = '0;
    unique case (lmul)
      2'd0: amask = 5'b00000;
      2'd1: amask = 5'b00001;
      2'd2: amask = 5'b00011;
      2'd3: amask = 5'b00111;
    endcase
    illegal = (|(vd_addr & amask)) || (|(vs1_addr & amask)) ||
              (|(vs2_addr & amask)) || (!vm && (vd_addr == 5'd0));
  end

  assign idx_last = 3'((4'd1 << lmul_q) - 4'd1);

  always_comb begin
    scalar_rep = '0;
    unique case (sew_q)
      2'd0: scalar_rep = {(VLEN/8){scalar_q[7:0]}};
      2'd1: scalar_rep = {(VLEN/16){scalar_q[15:0]}};
      2'd2: scalar_rep = {(VLEN/32){scalar_q[31:0]}};
      2'd3: scalar_rep = {(VLEN/64){scalar_q}};
    endcase
  end

  // Byte enables for the current group member: a byte is enabled when its
  // element's global index lies below min(vl, group size) and is not masked.
  always_comb begin
    int unsigned epr;
    int unsigned cap;
    int unsigned limit;
    epr   = VLENB >> sew_q;
    cap   = (32'd1 << lmul_q) * epr;
    limit = (32'(vl_q) < cap) ? 32'(vl_q) : cap;
    be    = '0;
    for (int unsigned b = 0; b < VLENB; b++) begin
      int unsigned     e;
      logic [VLEN-1:0] v0_sh;
      e     = 32'(idx_q) * epr + (b >> sew_q);
      v0_sh = v0_q >> e;
      if ((e < limit) && (vm_q || v0_sh[0])) begin
        be = be | (ONE_B << b);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    op_d         = op_q;
    sew_d        = sew_q;
    lmul_d       = lmul_q;
    vl_d         = vl_q;
    vm_d         = vm_q;
    use_scalar_d = use_scalar_q;
    scalar_d     = scalar_q;
    vs1_d        = vs1_q;
    vs2_d        = vs2_q;
    vd_d         = vd_q;
    v0_d         = v0_q;
    err_d        = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d         = op;
          sew_d        = sew;
          lmul_d       = lmul;
          vl_d         = vl;
          vm_d         = vm;
          use_scalar_d = use_scalar;
          scalar_d     = scalar;
          vs1_d        = vs1_addr;
          vs2_d        = vs2_addr;
          vd_d         = vd_addr;
          v0_d         = v0_data;
          idx_d        = '0;
          err_d        = illegal;
          state_d      = (illegal || (vl == '0)) ? FIN : READ;
        end
      end
      READ: state_d = EXEC;
      EXEC: begin
        if (idx_q == idx_last) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = READ;
        end
      end
      FIN:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      op_q         <= '0;
      sew_q        <= '0;
      lmul_q       <= '0;
      vl_q         <= '0;
      vm_q         <= '0;
      use_scalar_q <= '0;
      scalar_q     <= '0;
      vs1_q        <= '0;
      vs2_q        <= '0;
      vd_q         <= '0;
      v0_q         <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      op_q         <= op_d;
      sew_q        <= sew_d;
      lmul_q       <= lmul_d;
      vl_q         <= vl_d;
      vm_q         <= vm_d;
      use_scalar_q <= use_scalar_d;
      scalar_q     <= scalar_d;
      vs1_q        <= vs1_d;
      vs2_q        <= vs2_d;
      vd_q         <= vd_d;
      v0_q         <= v0_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    ready    = (state_q == IDLE);
    rd_addr1 = '0;
    rd_addr2 = '0;
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = '0;
    alu_sew  = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_be    = '0;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state_q)
      IDLE: ;
      READ: begin
        rd_addr1 = vs1_q + {2'b00, idx_q};
        rd_addr2 = vs2_q + {2'b00, idx_q};
      end
      EXEC: begin
        alu_a   = use_scalar_q ? scalar_rep : rd_data1;
        alu_b   = rd_data2;
        alu_op  = op_q;
        alu_sew = sew_q;
        wr_addr = vd_q + {2'b00, idx_q};
        wr_data = alu_result;
        wr_be   = be;
        wr_en   = |be;
      end
      FIN: begin
        done  = 1'b1;
        error = err_q;
      end
    endcase
  end

endmodule

// File: doc/vector_bitwise_seq.md
Name: vector_bitwise_seq

Overview:
- Sequencer that runs one vector bitwise/min/max instruction (vd = vs2 op vs1/scalar) across an LMUL register group using the combinational vector_bitwise_unit.
- Issues register-file reads per group member, drives the unit, and writes results back with byte enables for vl tail and v0 masking.
- Sits between vector decode/issue and the vector register file.

Parameters:
- VLEN, `MAX_VLEN (512): register width in bits; must equal the unit's width.
- VL_W, 10: width of vl; must hold 8*VLEN/8.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- start  input  1  launch request; accepted only when ready=1
- ready  output  1  high in IDLE
- op  input  5  bitwise_op code (AND/OR/XOR/NOT/MINU/MIN/MAXU/MAX)
- sew  input  2  00=8, 01=16, 10=32, 11=64
- lmul  input  2  00=1, 01=2, 10=4, 11=8 registers
- vl  input  VL_W  active element count
- vm  input  1  1 = unmasked; 0 = use v0
- use_scalar  input  1  operand A from scalar instead of vs1
- scalar  input  64  scalar operand; low SEW bits replicated
- vs1_addr, vs2_addr, vd_addr  input  5 each  base registers
- v0_data  input  VLEN  current v0 contents
- rd_addr1, rd_addr2  output  5 each  regfile read addresses (vs1, vs2); data valid next cycle
- rd_data1, rd_data2  input  VLEN each  regfile read data
- alu_a, alu_b  output  VLEN each  to unit dataA (vs1/scalar) and dataB (vs2)
- alu_op  output  5  to unit bitwise_op
- alu_sew  output  2  to unit sew
- alu_result  input  VLEN  from unit bitwise_result
- wr_en  output  1  regfile write strobe
- wr_addr  output  5  write register
- wr_data  output  VLEN  write data
- wr_be  output  VLEN/8  byte enables
- done  output  1  one-cycle completion pulse
- error  output  1  one-cycle pulse coincident with done on illegal config

Behaviour:
- Reset: state=IDLE; ready=1; wr_en, done, and error=0; rd_addr*, wr_addr, wr_be, alu_* are 0.
- Reset mid-operation: abort immediately to IDLE. No further writes, no done pulse.
- States: IDLE, READ, EXEC, FIN.
- IDLE: on start, latch op, sew, lmul, vl, vm, use_scalar, scalar, addresses and v0_data (v0 snapshot). Set idx=0.
  - Illegal config: any of vd/vs1/vs2 not a multiple of N=2^lmul, or vm=0 with vd=0. Go to FIN with error=1.
  - vl=0: go to FIN, no writes.
  - Otherwise go to READ.
- READ: rd_addr1=vs1+idx, rd_addr2=vs2+idx. Go to EXEC.
- EXEC:
  - alu_b=rd_data2.
  - alu_a=rd_data1, or the replicated scalar when use_scalar=1.
  - alu_op and alu_sew come from the latched values.
  - wr_addr=vd+idx, wr_data=alu_result.
  - wr_be computation: for element j of this register, global element e = idx*(VLEN/SEW)+j. Element j is active iff e < min(vl, N*VLEN/SEW) and (vm or v0snap[e]). All SEW/8 bytes of an active element are enabled.
  - wr_en=1 only if wr_be is nonzero.
  - If idx==N-1 go to FIN; else idx++ and go to READ.
- FIN: done=1 for one cycle, error as flagged. Return to IDLE.
- Timing: start sampled at edge 0 → first write at cycle 2; done at cycle 2N+1. Each register costs 2 cycles. ready returns at cycle 2N+2.
- start while ready=0 is ignored, not queued.
- Inputs are sampled only at accept; input changes during the operation have no effect.
- Masked-off and tail bytes are undisturbed: never enabled.
- Scalar replication: SEW=8 uses scalar[7:0] repeated VLEN/8 times, and so on up to SEW=64.
- vd overlapping vs1/vs2 at the same idx is legal. Each register is read before it is written.

Test Plan:
- AND, sew=00, lmul=00, vl=64, vm=1, v2=all 0xF0, v1=all 0x3C, vd=4, start at cycle 0 → single wr_en at cycle 2, wr_addr=4, wr_data all 0x30, wr_be all ones; done at cycle 3, ready at 4.
- MAXU, sew=10, vl=5, vm=1 → wr_be[19:0]=1 and rest 0; upper 11 lanes undisturbed.
- MIN, sew=01, vm=0, v0=0x…5555, vl=32, vs2 elements=-3, vs1 elements=2 → even elements written 0xFFFD, odd elements disabled; wr_be pattern 0x33…33.
- XOR with use_scalar=1, scalar=0x…00A5, sew=00, lmul=10 (N=4), vl=20, vs2=8, vd=16 → reads 8..11; first register has wr_be lanes 0-19 enabled with data = v8^0xA5; registers 17-19 not written (wr_en=0); done at cycle 9.
- lmul=01 with vd=3 → no rd/wr activity, done and error pulse together at cycle 1; also vm=0 with vd=0 → error.
- Assert reset at cycle 3 of an lmul=11 operation → at most one write observed, ready=1 next cycle, no done; then a new start completes normally.
